prog_load_ctrl: RTL and testbench

// Parametrised program/data loader and core-release sequencer for the RIDECORE harness.

---
 rtl/prog_load_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: program/data loader and core-release sequencer.
// It accepts a valid/ready word stream and writes it either into imem as
// packed fetch lines (mode 0) or into dmem as single words (mode 1). The core
// is held in reset while a session runs and is released after a programmable
// hold. A new session may be started again from RUN.
// Ports:
//   clk, reset                       clock (rising edge), async active-high reset
//   start, mode, base_addr, len      session request; mode/base/len latched on start
//   in_valid, in_ready, in_data      word stream (accepted when in_valid & in_ready)
//   imem_we, imem_addr, imem_wdata   imem line write port (lane 0 in the MSBs)
//   dmem_we, dmem_addr, dmem_wdata   dmem word write port (byte address)
//   loading                          memory ports owned by the loader
//   core_reset                       pipeline reset, active-high
//   done                             one-cycle pulse on entry to RUN
module prog_load_ctrl #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_W    = 9,
  parameter int DADDR_W        = 32,
  parameter int LEN_W          = 16,
  parameter int HOLD_CYCLES    = 2,
  parameter logic [WORD_W-1:0] PAD_WORD = 32'h00000013
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             mode,
  input  logic [DADDR_W-1:0]               base_addr,
  input  logic [LEN_W-1:0]                 len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_W-1:0]                in_data,
  output logic                             imem_we,
  output logic [LINE_ADDR_W-1:0]           imem_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0] imem_wdata,
  output logic                             dmem_we,
  output logic [DADDR_W-1:0]               dmem_addr,
  output logic [WORD_W-1:0]                dmem_wdata,
  output logic                             loading,
  output logic                             core_reset,
  output logic                             done
);

  localparam int LG     = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_HOLD, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic [LG-1:0]            lane_q, lane_d;
  logic [LINE_W-1:0]        line_q, line_d;
  logic [LINE_ADDR_W-1:0]   laddr_q, laddr_d;
  logic [DADDR_W-1:0]       daddr_q, daddr_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     imem_we_q, imem_we_d;
  logic [LINE_ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [LINE_W-1:0]        imem_wdata_q, imem_wdata_d;
  logic                     dmem_we_q, dmem_we_d;
  logic [DADDR_W-1:0]       dmem_addr_q, dmem_addr_d;
  logic [WORD_W-1:0]        dmem_wdata_q, dmem_wdata_d;
  logic                     done_q, done_d;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rem_d        = rem_q;
    lane_d       = lane_q;
    line_d       = line_q;
    laddr_d      = laddr_q;
    daddr_d      = daddr_q;
    hold_d       = '0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          mode_d  = mode;
          rem_d   = len;
          lane_d  = '0;
          // Pre-filling with PAD means a partial line needs no lane masking.
          line_d  = {WORDS_PER_LINE{PAD_WORD}};
          laddr_d = base_addr[LINE_ADDR_W+LG+1 : LG+2];
          daddr_d = base_addr;
          state_d = (len != '0) ? S_LOAD : S_HOLD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          rem_d = rem_q - LEN_W'(1);
          if (mode_q) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = daddr_q;
            dmem_wdata_d = in_data;
            daddr_d      = daddr_q + DADDR_W'(4);
          end else begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
              if (lane_q == LG'(i)) line_d[(WORDS_PER_LINE-1-i)*WORD_W +: WORD_W] = in_data;
            end
            lane_d = lane_q + LG'(1);
            if (lane_q == LG'(WORDS_PER_LINE-1)) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = laddr_q;
              imem_wdata_d = line_d;
              laddr_d      = laddr_q + LINE_ADDR_W'(1);
              line_d       = {WORDS_PER_LINE{PAD_WORD}};
            end
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = (!mode_q && lane_q != LG'(WORDS_PER_LINE-1)) ? S_FLUSH : S_HOLD;
          end
        end
      end
      S_FLUSH: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = laddr_q;
        imem_wdata_d = line_q;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES-1)) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      rem_q        <= '0;
      lane_q       <= '0;
      line_q       <= '0;
      laddr_q      <= '0;
      daddr_q      <= '0;
      hold_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rem_q        <= rem_d;
      lane_q       <= lane_d;
      line_q       <= line_d;
      laddr_q      <= laddr_d;
      daddr_q      <= daddr_d;
      hold_q       <= hold_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign loading    = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_HOLD);
  assign core_reset = (state_q != S_RUN);
  assign done       = done_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Testbench for prog_load_ctrl: directed sessions plus randomized sessions,
// checked against a write-list reference model built from the session rules.
module tb_prog_load_ctrl;

  localparam int HOLD = 2;
  localparam logic [31:0] PAD = 32'h00000013;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [15:0]  len = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         imem_we;
  logic [8:0]   imem_addr;
  logic [127:0] imem_wdata;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic         loading;
  logic         core_reset;
  logic         done;

  prog_load_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .len(len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .loading(loading), .core_reset(core_reset), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_d;
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: collect every strobe; a strobe must only appear while loading.
  always @(negedge clk) begin
    if (imem_we) begin
      got_q.push_back('{1'b0, {23'b0, imem_addr}, imem_wdata});
      check("imem_we_loading", 128'(loading), 128'(1));
    end
    if (dmem_we) begin
      got_q.push_back('{1'b1, dmem_addr, {96'b0, dmem_wdata}});
      check("dmem_we_loading", 128'(loading), 128'(1));
    end
  end

  // Reference: the complete list of writes one session must produce.
  task automatic build_expected(input bit m, input logic [31:0] base, input int n,
                                input logic [31:0] w[$]);
    int          l0;
    logic [127:0] line;
    exp_q.delete();
    if (m) begin
      for (int k = 0; k < n; k++)
        exp_q.push_back('{1'b1, base + 32'(4 * k), {96'b0, w[k]}});
    end else begin
      l0 = int'(base[12:4]);
      for (int j = 0; j < (n + 3) / 4; j++) begin
        line = '0;
        for (int i = 0; i < 4; i++)
          line = {line[95:0], (j * 4 + i < n) ? w[j * 4 + i] : PAD};
        exp_q.push_back('{1'b0, 32'((l0 + j) % 512), line});
      end
    end
  endtask

  task automatic run_session(input bit m, input logic [31:0] base, input int n,
                             input int gap, input bit seq);
    logic [31:0] w[$];
    int k, cyc, cnt, exp_hold;
    for (int i = 0; i < n; i++) w.push_back(seq ? 32'(i + 1) : $urandom);
    build_expected(m, base, n, w);
    got_q.delete();
    start = 1'b1; mode = m; base_addr = base; len = 16'(n);
    @(negedge clk);
    start = 1'b0;
    check("start_core_reset", 128'(core_reset), 128'(1));
    check("start_loading", 128'(loading), 128'(1));
    k = 0; cyc = 0;
    while (k < n && cyc < 2000) begin
      // Stray start/mode/len while loading must be ignored.
      start = ($urandom_range(0, 4) == 0); mode = $urandom_range(0, 1);
      len = 16'($urandom_range(0, 9)); base_addr = $urandom;
      if (in_ready && $urandom_range(0, 99) >= gap) begin
        in_valid = 1'b1; in_data = w[k]; k++;
      end else begin
        in_valid = 1'b0; in_data = $urandom;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    check("stream_accepted", 128'(k), 128'(n));
    exp_hold = HOLD + ((!m && (n % 4) != 0) ? 1 : 0);
    cnt = 0; cyc = 0;
    while (!done && cyc < 50) begin
      if (loading) cnt++;
      @(negedge clk); cyc++;
    end
    check("loading_after_last", 128'(cnt), 128'(exp_hold));
    check("done_pulse", 128'(done), 128'(1));
    check("run_core_reset", 128'(core_reset), 128'(0));
    check("run_loading", 128'(loading), 128'(0));
    for (int i = 0; i < 2; i++) begin
      in_valid = $urandom_range(0, 1); in_data = $urandom;
      @(negedge clk);
      check("done_single", 128'(done), 128'(0));
      check("run_ready", 128'(in_ready), 128'(0));
      check("run_core_reset_hold", 128'(core_reset), 128'(0));
    end
    in_valid = 1'b0;
    check("write_count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("write_kind", 128'(got_q[i].is_d), 128'(exp_q[i].is_d));
      check("write_addr", 128'(got_q[i].addr), 128'(exp_q[i].addr));
      check("write_data", got_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_we"}, 128'(imem_we), 128'(0));
    check({tag, "_dmem_we"}, 128'(dmem_we), 128'(0));
    check({tag, "_loading"}, 128'(loading), 128'(0));
    check({tag, "_core_reset"}, 128'(core_reset), 128'(1));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    check({tag, "_imem_addr"}, 128'(imem_addr), 128'(0));
    check({tag, "_imem_wdata"}, imem_wdata, 128'(0));
    check({tag, "_dmem_addr"}, 128'(dmem_addr), 128'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_reset", 128'(core_reset), 128'(1));
    check("idle_loading", 128'(loading), 128'(0));

    // Directed sessions.
    run_session(1'b0, 32'h0000_0000, 8, 0, 1'b1);
    run_session(1'b0, 32'h0000_0020, 5, 0, 1'b1);
    run_session(1'b1, 32'h0000_0100, 3, 60, 1'b1);
    run_session(1'b0, 32'h0000_0000, 0, 0, 1'b1);
    run_session(1'b1, 32'h0000_0040, 1, 0, 1'b1);
    run_session(1'b1, 32'hFFFF_FFF8, 4, 20, 1'b0);
    run_session(1'b0, 32'h0000_1FF7, 9, 20, 1'b0);

    // Reset in the middle of a mode-0 line: the partial line is dropped.
    got_q.delete();
    start = 1'b1; mode = 1'b0; base_addr = '0; len = 16'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'd1;
    @(negedge clk);
    in_data = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_writes", 128'(got_q.size()), 128'(0));
    check("midrst_idle_core_reset", 128'(core_reset), 128'(1));

    // Randomized sessions.
    for (int s = 0; s < 24; s++)
      run_session(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 13),
                  $urandom_range(0, 50), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
